// File: rtl/wb_machine_timer.sv
// wb_machine_timer: Wishbone pipelined slave with the RISC-V mtime/mtimecmp/msip registers.
// The slave always acks one cycle after it accepts a request and never stalls.
module wb_machine_timer #(
   parameter int PRESCALE  = 16,
   parameter int ADDR_BITS = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_wb_cyc,
   input  logic        i_wb_stb,
   input  logic        i_wb_we,
   input  logic [31:0] i_wb_addr,
   input  logic [31:0] i_wb_data,
   input  logic [3:0]  i_wb_sel,
   output logic        o_wb_ack,
   output logic        o_wb_stall,
   output logic [31:0] o_wb_data,
   output logic        o_timer_irq,
   output logic        o_soft_irq
);
   localparam int CW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
   logic [CW-1:0] cnt;
   logic [63:0] mtime, mtimecmp, mtime_next, cmp_next;
   logic [31:0] off, m, rd;
   logic msip, msip_next, tick, acc, wr, unused;
   assign off = 32'(i_wb_addr[ADDR_BITS-1:2]);
   assign unused = ^{i_wb_addr[31:ADDR_BITS], i_wb_addr[1:0]};
   assign tick = cnt == CW'(PRESCALE - 1);
   assign acc = i_wb_cyc & i_wb_stb;
   assign wr = acc & i_wb_we;
   assign m = {{8{i_wb_sel[3]}}, {8{i_wb_sel[2]}}, {8{i_wb_sel[1]}}, {8{i_wb_sel[0]}}};
   assign o_wb_stall = 1'b0;
   assign o_soft_irq = msip;
   // Written bytes override the incremented counter; unwritten bytes keep the tick.
   always_comb begin
      mtime_next = mtime + {63'd0, tick};
      cmp_next = mtimecmp;
      msip_next = (wr && off == 0 && i_wb_sel[0]) ? i_wb_data[0] : msip;
      if (wr && off == 1) cmp_next[31:0] = (mtimecmp[31:0] & ~m) | (i_wb_data & m);
      if (wr && off == 2) cmp_next[63:32] = (mtimecmp[63:32] & ~m) | (i_wb_data & m);
      if (wr && off == 3) mtime_next[31:0] = (mtime_next[31:0] & ~m) | (i_wb_data & m);
      if (wr && off == 4) mtime_next[63:32] = (mtime_next[63:32] & ~m) | (i_wb_data & m);
      rd = off == 0 ? {31'd0, msip} :
           off == 1 ? mtimecmp[31:0] :
           off == 2 ? mtimecmp[63:32] :
           off == 3 ? mtime[31:0] :
           off == 4 ? mtime[63:32] :
           off == 5 ? 32'(PRESCALE) : 32'd0;
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
         mtime <= '0;
         mtimecmp <= '1;
         msip <= 1'b0;
         o_wb_ack <= 1'b0;
         o_wb_data <= 32'd0;
         o_timer_irq <= 1'b0;
      end else begin
         cnt <= tick ? '0 : cnt + CW'(1);
         mtime <= mtime_next;
         mtimecmp <= cmp_next;
         msip <= msip_next;
         o_wb_ack <= acc;
         o_wb_data <= acc ? rd : 32'd0;
         o_timer_irq <= mtime_next >= cmp_next;
      end
   end
endmodule
